// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - SPART 8N1 receiver with 16x oversampling, rda/overrun/frame_err flags
// Optional 2-of-3 bit voting at ticks 7/8/9 is enabled by defining SPART_RX_MAJORITY_EN.
module spart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rxd,
  input  logic       clr_rda,
  output logic [7:0] rx_data,
  output logic       rda,
  output logic       overrun,
  output logic       frame_err,
  output logic       busy
);

  localparam int OSR = 16;
  localparam logic [3:0] TICK_LAST = 4'(OSR - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

  logic       rxd_m, rxd_s;
  logic [2:0] state, state_nxt;
  logic [3:0] tick_cnt, tick_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       s8;
  logic       bit_val;
  logic       stop_tick;
  logic       load, ferr_set;

`ifdef SPART_RX_MAJORITY_EN
  logic s7;
  assign bit_val = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
`else
  assign bit_val = s8;
`endif

  // The tick numbering counts the detection enable as tick 0, so every
  // decision keys off the value the counter is about to take.
  assign tick_nxt  = tick_cnt + 4'd1;
  assign stop_tick = enable && (state == STOP) && (tick_nxt == 4'd9);
  assign load      = stop_tick && bit_val;
  assign ferr_set  = stop_tick && !bit_val;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (enable && !rxd_s) state_nxt = START;
      START: begin
        if (enable) begin
          if ((tick_nxt == 4'd8) && rxd_s) state_nxt = IDLE;
          else if (tick_cnt == TICK_LAST)  state_nxt = DATA;
        end
      end
      DATA:      if (enable && (tick_cnt == TICK_LAST) && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:      if (stop_tick) state_nxt = bit_val ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (enable && rxd_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_m     <= 1'b1;
      rxd_s     <= 1'b1;
      state     <= IDLE;
      busy      <= 1'b0;
      tick_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      s8        <= 1'b0;
`ifdef SPART_RX_MAJORITY_EN
      s7        <= 1'b0;
`endif
      rx_data   <= 8'h00;
      rda       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);

      if (enable) begin
        if (state == IDLE) tick_cnt <= 4'd0;
        else               tick_cnt <= tick_nxt;

        if ((state == DATA) || (state == STOP)) begin
`ifdef SPART_RX_MAJORITY_EN
          if (tick_nxt == 4'd7) s7 <= rxd_s;
`endif
          if (tick_nxt == 4'd8) s8 <= rxd_s;
        end

        if ((state == START) && (tick_cnt == TICK_LAST)) bit_cnt <= 3'd0;

        if (state == DATA) begin
          if (tick_nxt == 4'd9)        shreg   <= {bit_val, shreg[7:1]};
          if (tick_cnt == TICK_LAST)   bit_cnt <= bit_cnt + 3'd1;
        end
      end

      if (load) rx_data <= shreg;

      // A load in the same cycle as a buffer read keeps rda set and suppresses overrun.
      if (load)         rda <= 1'b1;
      else if (clr_rda) rda <= 1'b0;

      if (load && rda && !clr_rda) overrun <= 1'b1;
      else if (clr_rda)            overrun <= 1'b0;

      if (ferr_set)     frame_err <= 1'b1;
      else if (clr_rda) frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - directed scoreboard bench for spart_rx
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rxd;
  logic       clr_rda;
  logic [7:0] rx_data;
  logic       rda;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int ecnt     = 0;
  int lat      = -1;
  logic busy_q = 1'b0;
  logic rda_q  = 1'b0;
  logic [7:0] sb[$];

  spart_rx dut (
    .clk(clk), .rst(rst), .enable(enable), .rxd(rxd), .clr_rda(clr_rda),
    .rx_data(rx_data), .rda(rda), .overrun(overrun), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // enable seen by the DUT on posedges where cyc % 4 == 1
  initial begin
    enable = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1 enable = (cyc % 4 == 0);
    end
  end

  // enables from the detection tick to the rda rise
  always @(negedge clk) begin
    if (enable) ecnt++;
    if (busy && !busy_q) ecnt = 0;
    if (rda && !rda_q) lat = ecnt;
    busy_q = busy;
    rda_q  = rda;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // lands 2ns after a posedge with cyc % 4 == 2, so detection is 3 clk later
  task automatic align();
    do begin
      @(posedge clk);
      #2;
    end while (cyc % 4 != 2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch, input int ncyc);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    align();
    for (int c = 0; c < ncyc; c++) begin
      rxd = fr[c / 64];
      if (glitch && c == 96) rxd = 1'b1;
      step(1);
    end
    rxd = 1'b1;
  endtask

  task automatic pulse_clr();
    clr_rda = 1'b1;
    step(1);
    clr_rda = 1'b0;
    step(2);
  endtask

  task automatic check_rx(input string tag);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: observed=empty_scoreboard expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk({tag, "_data"}, rx_data, exp);
      chk({tag, "_rda"}, rda, 1'b1);
    end
  endtask

  initial begin
    logic [7:0] maj_exp;
    rst = 1'b1; rxd = 1'b1; clr_rda = 1'b0;
    step(3);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_rda", rda, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step(10);

    sb.push_back(8'hA6);
    send_frame(8'hA6, 1'b1, 1'b0, 640);
    chk("a6_latency", lat, 153);
    check_rx("a6");
    chk("a6_frame_err", frame_err, 1'b0);
    chk("a6_overrun", overrun, 1'b0);
    pulse_clr();
    chk("a6_clr_rda", rda, 1'b0);

    align();
    rxd = 1'b0;
    step(16);
    chk("glitch_busy_hi", busy, 1'b1);
    rxd = 1'b1;
    step(30);
    chk("glitch_busy_lo", busy, 1'b0);
    chk("glitch_rda", rda, 1'b0);
    sb.push_back(8'h59);
    send_frame(8'h59, 1'b1, 1'b0, 640);
    check_rx("post_glitch");
    pulse_clr();

    sb.push_back(8'h59);
    send_frame(8'h59, 1'b1, 1'b0, 640);
    check_rx("ovr_first");
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0, 640);
    check_rx("ovr_second");
    chk("ovr_flag", overrun, 1'b1);
    pulse_clr();
    chk("ovr_clr_rda", rda, 1'b0);
    chk("ovr_clr_overrun", overrun, 1'b0);

    send_frame(8'h59, 1'b0, 1'b0, 640);
    chk("brk_frame_err", frame_err, 1'b1);
    chk("brk_rda", rda, 1'b0);
    chk("brk_rx_data", rx_data, 8'h3C);
    chk("brk_wait_busy", busy, 1'b1);
    step(10);
    chk("brk_idle_busy", busy, 1'b0);
    pulse_clr();
    chk("brk_clr_frame_err", frame_err, 1'b0);

`ifdef SPART_RX_MAJORITY_EN
    maj_exp = 8'h00;
`else
    maj_exp = 8'h01;
`endif
    sb.push_back(maj_exp);
    send_frame(8'h00, 1'b1, 1'b1, 640);
    check_rx("vote");

    send_frame(8'hC3, 1'b1, 1'b0, 288);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_rda", rda, 1'b0);
    chk("mrst_rx_data", rx_data, 8'h00);
    chk("mrst_overrun", overrun, 1'b0);
    chk("mrst_frame_err", frame_err, 1'b0);
    step(2);
    rst = 1'b0;
    step(10);
    sb.push_back(8'hC3);
    send_frame(8'hC3, 1'b1, 1'b0, 640);
    check_rx("c3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
